// File: rtl/flag_cond_unit_if.sv
// Bus between the sequencer/ALU side and flag_cond_unit: ALU flag capture,
// branch-condition requests, shadow save/restore, and the registered results.
interface flag_cond_unit_if #(
  parameter int OP_W   = 5,
  parameter int COND_W = 4
);
  logic              alu_valid;
  logic [OP_W-1:0]   alu_op;
  logic              alu_o;
  logic              alu_c;
  logic              alu_s;
  logic              alu_z;
  logic              cond_valid;
  logic [COND_W-1:0] cond_code;
  logic              save;
  logic              restore;
  logic [3:0]        flags;
  logic              taken;
  logic              taken_valid;
  logic              shadow_valid;

  modport master (
    output alu_valid, alu_op, alu_o, alu_c, alu_s, alu_z,
    output cond_valid, cond_code, save, restore,
    input  flags, taken, taken_valid, shadow_valid
  );

  modport slave (
    input  alu_valid, alu_op, alu_o, alu_c, alu_s, alu_z,
    input  cond_valid, cond_code, save, restore,
    output flags, taken, taken_valid, shadow_valid
  );
endinterface

// File: rtl/flag_cond_unit.sv
// Architectural {O,C,S,Z} flag register fed by the ALU with per-opcode update
// masks, bypassed branch-condition evaluation, and a one-deep interrupt shadow.
module flag_cond_unit #(
  parameter int         OP_W      = 5,
  parameter int         COND_W    = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  flag_cond_unit_if.slave  bus
);

  typedef enum logic [3:0] {
    CC_AL  = 4'b0000,
    CC_O   = 4'b0001,
    CC_C   = 4'b0010,
    CC_S   = 4'b0011,
    CC_Z   = 4'b0100,
    CC_NO  = 4'b0101,
    CC_NC  = 4'b0110,
    CC_NS  = 4'b0111,
    CC_NZ  = 4'b1000,
    CC_LE0 = 4'b1001,
    CC_GT0 = 4'b1010,
    CC_LT  = 4'b1011,
    CC_GE  = 4'b1100,
    CC_LE  = 4'b1101,
    CC_NV0 = 4'b1110,
    CC_NV1 = 4'b1111
  } cond_e;

  logic [3:0] flags_q,  flags_d;
  logic [3:0] shadow_q, shadow_d;
  logic       shadow_valid_q, shadow_valid_d;
  logic       taken_q, taken_d;
  logic       taken_valid_q, taken_valid_d;

  logic [4:0] op;
  logic [3:0] upd_mask;
  logic [3:0] alu_flags;
  logic [3:0] alu_next;
  logic       f_o, f_c, f_s, f_z;
  logic       cond_hit;
  cond_e      cc;

  assign op        = 5'(bus.alu_op);
  assign alu_flags = {bus.alu_o, bus.alu_c, bus.alu_s, bus.alu_z};
  assign cc        = cond_e'(4'(bus.cond_code));

  // Mask bits are {O,C,S,Z}; 00010/00111 and 01010-01111 are undefined and
  // fall to the no-update default along with the explicit no-flag opcodes.
  always_comb begin
    upd_mask = 4'b0000;
    case (op)
      5'b00000, 5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110: upd_mask = 4'b1111;
      5'b01000, 5'b01001:           upd_mask = 4'b0111;
      5'b10000:                     upd_mask = 4'b0001;
      5'b10011, 5'b11111:           upd_mask = 4'b0000;
      default:                      upd_mask = op[4] ? 4'b0011 : 4'b0000;
    endcase
  end

  assign alu_next = (flags_q & ~upd_mask) | (alu_flags & upd_mask);

  // Restore always drops the ALU write, even when there is nothing to restore.
  always_comb begin
    flags_d        = flags_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    if (bus.restore) begin
      if (shadow_valid_q) begin
        flags_d = shadow_q;
      end
      shadow_valid_d = 1'b0;
    end else begin
      if (bus.alu_valid) begin
        flags_d = alu_next;
      end
      if (bus.save) begin
        shadow_d       = flags_d;
        shadow_valid_d = 1'b1;
      end
    end
  end

  // Conditions see the post-update flags so a branch right after a compare is fresh.
  assign {f_o, f_c, f_s, f_z} = flags_d;

  always_comb begin
    cond_hit = 1'b0;
    case (cc)
      CC_AL:  cond_hit = 1'b1;
      CC_O:   cond_hit = f_o;
      CC_C:   cond_hit = f_c;
      CC_S:   cond_hit = f_s;
      CC_Z:   cond_hit = f_z;
      CC_NO:  cond_hit = ~f_o;
      CC_NC:  cond_hit = ~f_c;
      CC_NS:  cond_hit = ~f_s;
      CC_NZ:  cond_hit = ~f_z;
      CC_LE0: cond_hit = f_s | f_z;
      CC_GT0: cond_hit = ~f_s & ~f_z;
      CC_LT:  cond_hit = f_s ^ f_o;
      CC_GE:  cond_hit = ~(f_s ^ f_o);
      CC_LE:  cond_hit = (f_s ^ f_o) | f_z;
      CC_NV0: cond_hit = 1'b0;
      CC_NV1: cond_hit = 1'b0;
      default: cond_hit = 1'b0;
    endcase
  end

  always_comb begin
    taken_d       = taken_q;
    taken_valid_d = bus.cond_valid;
    if (bus.cond_valid) begin
      taken_d = cond_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q        <= FLAGS_RST;
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
      taken_q        <= 1'b0;
      taken_valid_q  <= 1'b0;
    end else begin
      flags_q        <= flags_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      taken_q        <= taken_d;
      taken_valid_q  <= taken_valid_d;
    end
  end

  assign bus.flags        = flags_q;
  assign bus.taken        = taken_q;
  assign bus.taken_valid  = taken_valid_q;
  assign bus.shadow_valid = shadow_valid_q;

endmodule
